// File: rtl/logic_unit_arbiter_pkg.sv
// logic_arb_pkg: shared types and constants for the logic_unit_arbiter block.
//   arb_state_t : arbiter FSM states (IDLE, EXEC, RESP)
//   OP_W        : width of the LogicUnit operation code
//   STAT_W      : width of the optional statistics counters
package logic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int OP_W   = 3;
  localparam int STAT_W = 32;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: request/response bundle between the requesters and
// the arbiter.
//   req_valid  [NUM_REQ]             per-requester request valid
//   req_ready  [NUM_REQ]             per-requester accept (one-hot or zero)
//   req_a/b    [NUM_REQ][DATA_WIDTH] operands per requester
//   req_op     [NUM_REQ][OP_W]       operation code per requester
//   rsp_valid / rsp_ready            response handshake
//   rsp_id     [ID_W]                requester that owns the response
//   rsp_result [DATA_WIDTH]          LogicUnit result
// Modports: master = requester/consumer side, slave = arbiter side.
interface logic_unit_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  import logic_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0][OP_W-1:0]       req_op;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [ID_W-1:0]                    rsp_id;
  logic [DATA_WIDTH-1:0]              rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/LogicUnit.sv
// LogicUnit: shared combinational bitwise logic datapath.
//   a, b   [DATA_WIDTH] operands
//   op     [OP_W]       operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR,
//                       5 XNOR, 6 AND-NOT (a & ~b), 7 NOT a
//   result [DATA_WIDTH] combinational result
module LogicUnit
  import logic_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_W-1:0]       op,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      3'd0:    result = a & b;
      3'd1:    result = a | b;
      3'd2:    result = a ^ b;
      3'd3:    result = ~(a & b);
      3'd4:    result = ~(a | b);
      3'd5:    result = ~(a ^ b);
      3'd6:    result = a & ~b;
      3'd7:    result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req   [NUM_REQ]        request vector
//   ptr   [ID_W]           index where the search starts (highest priority)
//   grant [NUM_REQ]        one-hot grant, zero when no request is set
//   idx   [ID_W]           index of the granted requester (0 when none)
//   any                    at least one request is set
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Walk the requesters starting at ptr, wrapping at NUM_REQ; the first set
  // request wins. NUM_REQ need not be a power of two, hence the modulo.
  always_comb begin
    int  cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
    any = found;
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one LogicUnit among NUM_REQ requesters with
// round-robin arbitration and a tagged valid/ready response channel.
// One transaction at a time: IDLE (arbitrate + capture operands) ->
// EXEC (LogicUnit evaluates, result captured) -> RESP (hold until consumed).
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    logic_unit_arbiter_if.slave (requests in, tagged response out)
// Optional feature (macro LOGIC_ARB_STATS_EN):
//   stat_done  [STAT_W] completed responses (rsp_valid & rsp_ready), wraps
//   stat_stall [STAT_W] cycles spent in RESP with rsp_ready low, wraps
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_done,
  output logic [STAT_W-1:0]    stat_stall
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t            state;
  arb_state_t            state_nxt;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       id_q;
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [OP_W-1:0]       op_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] lu_result;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  logic                  accept;
  logic                  complete;

  // Pointer to the requester after the one just served, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  LogicUnit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_logic_unit (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .result (lu_result)
  );

  assign accept   = (state == IDLE) && pick_any;
  assign complete = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is also masked by rst_n so that no requester sees an accept
  // while the block is held in reset.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          bus.req_ready = pick_grant;
        end
        if (pick_any) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage boundary: IDLE -> EXEC, winner's operands and tag are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
      op_q  <= '0;
      id_q  <= '0;
    end else if (accept) begin
      opa_q <= bus.req_a[pick_idx];
      opb_q <= bus.req_b[pick_idx];
      op_q  <= bus.req_op[pick_idx];
      id_q  <= pick_idx;
    end
  end

  // Stage boundary: EXEC -> RESP, LogicUnit result is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (state == EXEC) begin
      res_q <= lu_result;
    end
  end

  // The pointer moves only when a response is consumed, so a requester that
  // keeps its request up is served within NUM_REQ transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (complete) begin
      rr_ptr <= next_ptr(id_q);
    end
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done  <= '0;
      stat_stall <= '0;
    end else begin
      if (complete) begin
        stat_done <= stat_done + STAT_W'(1);
      end
      if ((state == RESP) && !bus.rsp_ready) begin
        stat_stall <= stat_stall + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one `LogicUnit` instance among `NUM_REQ` requesters (decode lanes, address-gen, CSR path) using round-robin arbitration. It registers the winning operands, drives the shared `LogicUnit`, and registers its result. The result returns on a single tagged response channel with valid/ready backpressure. The block sits between issue logic and the logic datapath; it is the only driver of that `LogicUnit`.

## Interface
- `DATA_WIDTH`, 32, operand/result width, forwarded to `LogicUnit`
- `NUM_REQ`, 4, number of requesters, 2..8
- `ID_W`, `$clog2(NUM_REQ)`, requester tag width (localparam)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `req_a`  in  NUM_REQ×DATA_WIDTH  operand A per requester
- `req_b`  in  NUM_REQ×DATA_WIDTH  operand B per requester
- `req_op`  in  NUM_REQ×3  operation code per requester
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  ID_W  index of the requester that owns the response
- `rsp_result`  out  DATA_WIDTH  registered `LogicUnit` result

## Operation
- FSM states: IDLE, EXEC, RESP; reset state IDLE.
- IDLE:
  - If any `req_valid` is set, pick the winner by round-robin, starting the search at `rr_ptr`.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - On the clock edge, capture `req_a/b/op[winner]` into operand registers, capture the winner into `id_q`, and go to EXEC.
- EXEC: registered operands drive `LogicUnit`. Its `result` is captured into `res_q` at the edge. Go to RESP.
- RESP:
  - `rsp_valid` is 1; `rsp_id`=`id_q`; `rsp_result`=`res_q`.
  - These outputs stay stable until `rsp_ready`=1 at a clock edge.
  - At that edge, `rr_ptr` ← `(id_q+1) mod NUM_REQ` and the FSM goes to IDLE.
- `req_ready` is all-zero outside IDLE. A requester must hold `req_valid` and its operands until it sees `req_ready`.
- Round-robin rules:
  - `rr_ptr` advances only on response completion.
  - A requester that keeps requesting continuously is granted at least once every `NUM_REQ` transactions.
- Op codes are passed to `LogicUnit` unmodified. The arbiter never decodes them.
- Reset mid-transaction: all state is dropped with no response emitted; `rr_ptr`=0.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0
  - `rr_ptr`=0, operand regs=0, FSM=IDLE
- Latency: accept edge at cycle N → `rsp_valid` high during cycle N+2.
- Max throughput: one transaction per 3 cycles, reached when `rsp_ready` is held at 1.
- Requests that arrive while the FSM is in EXEC or RESP are not seen until the next IDLE cycle.
- A simultaneous `req_valid` on a requester plus a completing response is handled as follows: the RESP→IDLE transition takes one cycle, and arbitration happens in that IDLE cycle.
- `rsp_ready` held low: the FSM stays in RESP indefinitely with no loss and no change to the outputs.

## Configuration
- `LOGIC_ARB_STATS_EN`, when defined, adds:
  - output `stat_done`, 32 bits: counts completed responses (`rsp_valid & rsp_ready`). Reset value 0; wraps 0xFFFFFFFF→0.
  - output `stat_stall`, 32 bits: counts cycles in RESP with `rsp_ready`=0. Reset value 0; wraps 0xFFFFFFFF→0.
- When the macro is undefined, these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `logic_arb_pkg`:
  - `arb_state_t` enum {IDLE, EXEC, RESP}
  - localparam `OP_W`=3
  - stats counter width localparam `STAT_W`=32
- Sub-module `rr_picker`: combinational. Inputs are the request vector and the pointer; outputs are a one-hot grant and its index.
- `LogicUnit` is instantiated once inside the block.

## Test plan
- Single request, `req_valid[2]`=1, a=0x0000_00FF, b=0x0F0F_0F0F, op=3'd1, `rsp_ready`=1 → `req_ready[2]` pulses one cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=2, and `rsp_result` equals the `LogicUnit` output for those operands.
- All four requesters held valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0; one response every 3 cycles.
- Response backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_result` stay constant; no `req_ready` is asserted; completion follows on the first cycle with `rsp_ready`=1.
- Requesters 1 and 3 valid, `rr_ptr`=2 → requester 3 wins first, then requester 1.
- Assert `rst_n`=0 while in EXEC → outputs return to reset values immediately; after release, the FSM is in IDLE, `rr_ptr`=0, and no stale response appears.
- With `LOGIC_ARB_STATS_EN`, run 3 transactions with 2 stall cycles total → `stat_done`=3, `stat_stall`=2.
